ma_stage: RTL and testbench
===========================

MA_STAGE -- requirements
Module: ma_stage

Interface
REQ-001 Parameters SHALL be none; all widths are fixed constants from the shared package.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 ex_validout  in  1  upstream stage holds a valid instruction.
REQ-005 ma_allowin  out  1  this stage accepts ex_to_ma_bus this cycle.
REQ-006 ex_to_ma_bus  in  74  {res_from_mem[73], ld_op[72:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
REQ-007 wb_allowin  in  1  downstream writeback stage can accept.
REQ-008 ma_validout  out  1  ma_to_wb_bus is valid and complete this cycle.
REQ-009 ma_to_wb_bus  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
REQ-010 ma_to_id_bus  out  39  {ma_gr_we[38], dest[37:33], final_result[32:1], load_pending[0]} for forwarding/interlock.
REQ-011 data_sram_data_ok  in  1  one-cycle pulse: read data for the oldest outstanding load is on data_sram_rdata.
REQ-012 data_sram_rdata  in  32  load return data, valid only while data_ok=1.

Function
REQ-013 Handshake: ma_allowin = ~valid | (readygo & wb_allowin); ma_validout = valid & readygo.
REQ-014 On ex_validout & ma_allowin the bus SHALL be captured into an internal register at the next edge; valid <= ex_validout whenever ma_allowin=1.
REQ-015 readygo SHALL be 1 for non-load (res_from_mem=0) instructions, giving exactly one cycle of stage latency.
REQ-016 Load FSM states: IDLE (no load or load complete), WAIT (load captured, data_ok not yet seen), HOLD (data_ok seen, data buffered, waiting for wb_allowin).
REQ-017 Transitions: capture of a load -> WAIT; WAIT & data_ok & wb_allowin -> IDLE or WAIT per next capture; WAIT & data_ok & ~wb_allowin -> HOLD; HOLD & wb_allowin -> IDLE or WAIT per next capture.
REQ-018 readygo for a load SHALL be 1 in WAIT only in the data_ok cycle (data passed combinationally) and 1 throughout HOLD.
REQ-019 In HOLD the buffered rdata SHALL be used; data_sram_rdata SHALL be ignored.
REQ-020 data_ok while valid=0 or in IDLE/HOLD SHALL be ignored (stale/discarded response).
REQ-021 ld_op encoding: 000 W, 001 B, 010 BU, 011 H, 100 HU; other codes SHALL behave as W.
REQ-022 Byte lane = alu_result[1:0]; half lane = alu_result[1]; B/H sign-extend, BU/HU zero-extend to 32 bits.
REQ-023 final_result = extracted load data when res_from_mem=1, else alu_result.
REQ-024 ma_gr_we = gr_we & valid; ma_to_id_bus dest SHALL be dest & {5{valid}}.
REQ-025 load_pending = valid & res_from_mem & ~readygo (ID must stall, not forward).
REQ-026 Simultaneous drain and fill (ma_validout & wb_allowin & ex_validout) SHALL replace the instruction with no bubble.

Reset
REQ-027 On rst_n=0: valid=0, FSM=IDLE, bus register=0, data buffer=0, asynchronously.
REQ-028 Outputs under reset: ma_allowin=1, ma_validout=0, ma_to_wb_bus=0, ma_to_id_bus=0.
REQ-029 Reset asserted in WAIT SHALL abandon the load; a data_ok arriving after release with valid=0 is dropped per REQ-020.

Structure
REQ-030 Bus widths (74/70/39) and ld_op codes SHALL live in the shared pipeline package used by all stages.
REQ-031 Load extraction/extension SHALL be one combinational sub-module, load_align (inputs ld_op, addr[1:0], rdata; output 32-bit result).

Verification
REQ-032 Non-load: gr_we=1, dest=5, alu_result=0x1234, wb_allowin=1 -> next cycle ma_validout=1, final_result=0x1234, ma_to_id_bus gr_we=1, dest=5.
REQ-033 LD.B at addr low bits 2, data_ok one cycle later with rdata 0x00800000 -> final_result 0xFFFFFF80; load_pending=1 until data_ok cycle.
REQ-034 LD.HU at addr low bits 2, rdata 0x8001_0000, wb_allowin=0 for 3 cycles -> HOLD; result 0x00008001 stable; ma_allowin=0 until wb_allowin=1.
REQ-035 Back-to-back ALU ops with wb_allowin=1 every cycle -> one result per cycle, pcs in order, no bubbles.
REQ-036 Assert rst_n=0 while in WAIT, release, then pulse data_ok -> ma_validout stays 0, no write reaches wb.
REQ-037 LD.W, data_ok held off 4 cycles -> ma_validout=0 and load_pending=1 throughout; on data_ok, final_result equals rdata.

Source files
------------

// File: rtl/ma_stage_pkg.sv
// Shared pipeline definitions: bus widths, load-op codes, MA bus layout and load FSM states.
package ma_stage_pkg;

    localparam int unsigned EX_MA_W = 74;
    localparam int unsigned MA_WB_W = 70;
    localparam int unsigned MA_ID_W = 39;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_BU = 3'b010,
        LD_H  = 3'b011,
        LD_HU = 3'b100
    } ld_op_e;

    typedef struct packed {
        logic        res_from_mem;
        logic [2:0]  ld_op;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } ex_ma_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ld_state_e;

endpackage

// File: rtl/ma_stage_load_align.sv
// Load data lane selection and sign/zero extension.
module load_align
    import ma_stage_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half lane and extend it according to the load op
    always_comb begin
        unique case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (ld_op)
            LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   result = {24'h0, byte_sel};
            LD_H:    result = {{16{half_sel[15]}}, half_sel};
            LD_HU:   result = {16'h0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/ma_stage.sv
// Memory-access pipeline stage: holds one instruction, waits for load data, forwards to WB.
module ma_stage
    import ma_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_validout,
    output logic                 ma_allowin,
    input  logic [EX_MA_W-1:0]   ex_to_ma_bus,
    input  logic                 wb_allowin,
    output logic                 ma_validout,
    output logic [MA_WB_W-1:0]   ma_to_wb_bus,
    output logic [MA_ID_W-1:0]   ma_to_id_bus,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata
);

    ex_ma_t    ex_bus;
    ex_ma_t    bus_q;
    logic      valid_q;
    ld_state_e state_q, state_d;
    logic [31:0] buf_q;

    logic        readygo;
    logic        capture;
    logic        load_accept;
    logic [31:0] raw_data;
    logic [31:0] load_data;
    logic [31:0] final_result;
    logic        load_pending;

    assign ex_bus      = ex_ma_t'(ex_to_ma_bus);
    assign ma_allowin  = ~valid_q | (readygo & wb_allowin);
    assign ma_validout = valid_q & readygo;
    assign capture     = ex_validout & ma_allowin;
    assign load_accept = capture & ex_bus.res_from_mem;

    // State register and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            bus_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            if (ma_allowin) begin
                valid_q <= ex_validout;
            end
            if (capture) begin
                bus_q <= ex_bus;
            end
            if (state_q == S_WAIT && valid_q && data_sram_data_ok && !wb_allowin) begin
                buf_q <= data_sram_rdata;
            end
        end
    end

    // Load FSM next-state; data_ok is only honoured while a valid load is waiting
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_accept) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (valid_q && data_sram_data_ok) begin
                    if (wb_allowin) state_d = load_accept ? S_WAIT : S_IDLE;
                    else            state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (wb_allowin) state_d = load_accept ? S_WAIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ready-to-go and load data source selection from FSM state
    always_comb begin
        readygo  = 1'b1;
        raw_data = data_sram_rdata;
        if (bus_q.res_from_mem) begin
            case (state_q)
                S_WAIT:  readygo = data_sram_data_ok;
                S_HOLD:  begin
                    readygo  = 1'b1;
                    raw_data = buf_q;
                end
                default: readygo = 1'b0;
            endcase
        end
    end

    load_align u_load_align (
        .ld_op  (bus_q.ld_op),
        .addr   (bus_q.alu_result[1:0]),
        .rdata  (raw_data),
        .result (load_data)
    );

    assign final_result = bus_q.res_from_mem ? load_data : bus_q.alu_result;
    assign load_pending = valid_q & bus_q.res_from_mem & ~readygo;

    assign ma_to_wb_bus = {bus_q.gr_we, bus_q.dest, final_result, bus_q.pc};
    assign ma_to_id_bus = {bus_q.gr_we & valid_q, bus_q.dest & {5{valid_q}},
                           final_result, load_pending};

endmodule

// File: tb/tb_ma_stage.sv
// Directed self-checking bench for ma_stage.
module tb_ma_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_validout;
    logic        ma_allowin;
    logic [73:0] ex_to_ma_bus;
    logic        wb_allowin;
    logic        ma_validout;
    logic [69:0] ma_to_wb_bus;
    logic [38:0] ma_to_id_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    int tests;
    int fails;

    ma_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ex_validout       (ex_validout),
        .ma_allowin        (ma_allowin),
        .ex_to_ma_bus      (ex_to_ma_bus),
        .wb_allowin        (wb_allowin),
        .ma_validout       (ma_validout),
        .ma_to_wb_bus      (ma_to_wb_bus),
        .ma_to_id_bus      (ma_to_id_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [73:0] mk(input logic rfm, input logic [2:0] op, input logic we,
                                       input logic [4:0] d, input logic [31:0] alu,
                                       input logic [31:0] pc);
        return {rfm, op, we, d, alu, pc};
    endfunction

    task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single-cycle load: capture, data_ok next cycle, check extracted result
    task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        @(negedge clk);
        ex_validout  = 1'b1;
        ex_to_ma_bus = mk(1'b1, op, 1'b1, 5'd9, addr, 32'h500);
        @(negedge clk);
        ex_validout       = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rdata;
        #1;
        chk(tag, {42'h0, ma_to_wb_bus[63:32]}, {42'h0, exp});
        @(negedge clk);
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        ex_validout = 1'b0;
        ex_to_ma_bus = '0;
        wb_allowin = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;

        // Reset state
        #1;
        chk("rst_allowin", 74'(ma_allowin), 74'(1'b1));
        chk("rst_validout", 74'(ma_validout), 74'(1'b0));
        chk("rst_wb_bus", 74'(ma_to_wb_bus), 74'h0);
        chk("rst_id_bus", 74'(ma_to_id_bus), 74'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-load: one cycle latency
        @(negedge clk);
        ex_validout  = 1'b1;
        ex_to_ma_bus = mk(1'b0, 3'b000, 1'b1, 5'd5, 32'h1234, 32'h100);
        @(negedge clk);
        ex_validout = 1'b0;
        #1;
        chk("alu_validout", 74'(ma_validout), 74'(1'b1));
        chk("alu_wb_bus", 74'(ma_to_wb_bus), 74'({1'b1, 5'd5, 32'h1234, 32'h100}));
        chk("alu_id_bus", 74'(ma_to_id_bus), 74'({1'b1, 5'd5, 32'h1234, 1'b0}));

        // LD.B lane 2, data_ok one cycle later
        @(negedge clk);
        ex_validout  = 1'b1;
        ex_to_ma_bus = mk(1'b1, 3'b001, 1'b1, 5'd7, 32'h1002, 32'h200);
        @(negedge clk);
        ex_validout = 1'b0;
        #1;
        chk("ldb_wait_validout", 74'(ma_validout), 74'(1'b0));
        chk("ldb_wait_pending", 74'(ma_to_id_bus[0]), 74'(1'b1));
        chk("ldb_wait_allowin", 74'(ma_allowin), 74'(1'b0));
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0080_0000;
        #1;
        chk("ldb_ok_validout", 74'(ma_validout), 74'(1'b1));
        chk("ldb_ok_result", 74'(ma_to_wb_bus[63:32]), 74'(32'hFFFF_FF80));
        chk("ldb_ok_pending", 74'(ma_to_id_bus[0]), 74'(1'b0));
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        chk("ldb_drained", 74'(ma_validout), 74'(1'b0));

        // LD.HU lane 1 with WB stalled for 3 cycles -> HOLD, then drain+fill
        wb_allowin   = 1'b0;
        ex_validout  = 1'b1;
        ex_to_ma_bus = mk(1'b1, 3'b100, 1'b1, 5'd3, 32'h2002, 32'h2A0);
        @(negedge clk);
        ex_validout       = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8001_0000;
        #1;
        chk("hu_ok_validout", 74'(ma_validout), 74'(1'b1));
        chk("hu_ok_allowin", 74'(ma_allowin), 74'(1'b0));
        chk("hu_ok_result", 74'(ma_to_wb_bus[63:32]), 74'(32'h0000_8001));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'hDEAD_BEEF;
            #1;
            chk("hu_hold_result", 74'(ma_to_wb_bus[63:32]), 74'(32'h0000_8001));
            chk("hu_hold_allowin", 74'(ma_allowin), 74'(1'b0));
            chk("hu_hold_validout", 74'(ma_validout), 74'(1'b1));
        end
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        wb_allowin   = 1'b1;
        ex_validout  = 1'b1;
        ex_to_ma_bus = mk(1'b0, 3'b000, 1'b1, 5'd4, 32'hABCD, 32'h300);
        #1;
        chk("hu_stale_ok_result", 74'(ma_to_wb_bus[63:32]), 74'(32'h0000_8001));
        chk("hu_release_allowin", 74'(ma_allowin), 74'(1'b1));
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        ex_validout       = 1'b0;
        #1;
        chk("fill_validout", 74'(ma_validout), 74'(1'b1));
        chk("fill_wb_bus", 74'(ma_to_wb_bus), 74'({1'b1, 5'd4, 32'hABCD, 32'h300}));

        // Back-to-back ALU ops, no bubbles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ex_validout  = 1'b1;
            ex_to_ma_bus = mk(1'b0, 3'b000, 1'b1, 5'(i + 10), 32'(i * 17), 32'h400 + 32'(i * 4));
            #1;
            if (i > 0) begin
                chk("b2b_validout", 74'(ma_validout), 74'(1'b1));
                chk("b2b_pc", 74'(ma_to_wb_bus[31:0]), 74'(32'h400 + 32'((i - 1) * 4)));
            end
        end
        @(negedge clk);
        ex_validout = 1'b0;
        #1;
        chk("b2b_last_pc", 74'(ma_to_wb_bus[31:0]), 74'(32'h40C));
        chk("b2b_last_res", 74'(ma_to_wb_bus[63:32]), 74'(32'd51));
        @(negedge clk);
        #1;
        chk("b2b_idle", 74'(ma_validout), 74'(1'b0));

        // Reset while waiting for load data; late data_ok must be dropped
        ex_validout  = 1'b1;
        ex_to_ma_bus = mk(1'b1, 3'b000, 1'b1, 5'd6, 32'h3000, 32'h600);
        @(negedge clk);
        ex_validout = 1'b0;
        #1;
        chk("rw_pending", 74'(ma_to_id_bus[0]), 74'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("rw_rst_validout", 74'(ma_validout), 74'(1'b0));
        chk("rw_rst_allowin", 74'(ma_allowin), 74'(1'b1));
        chk("rw_rst_id_bus", 74'(ma_to_id_bus), 74'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_0055;
        #1;
        chk("rw_late_validout", 74'(ma_validout), 74'(1'b0));
        chk("rw_late_wb_bus", 74'(ma_to_wb_bus), 74'h0);
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        chk("rw_after_validout", 74'(ma_validout), 74'(1'b0));
        chk("rw_after_allowin", 74'(ma_allowin), 74'(1'b1));

        // LD.W with data_ok held off 4 cycles
        ex_validout  = 1'b1;
        ex_to_ma_bus = mk(1'b1, 3'b000, 1'b1, 5'd8, 32'h3000, 32'h700);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ex_validout = 1'b0;
            #1;
            chk("ldw_wait_validout", 74'(ma_validout), 74'(1'b0));
            chk("ldw_wait_pending", 74'(ma_to_id_bus[0]), 74'(1'b1));
        end
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        #1;
        chk("ldw_ok_validout", 74'(ma_validout), 74'(1'b1));
        chk("ldw_ok_result", 74'(ma_to_wb_bus[63:32]), 74'(32'hCAFE_F00D));
        chk("ldw_ok_pending", 74'(ma_to_id_bus[0]), 74'(1'b0));
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        chk("ldw_drained", 74'(ma_validout), 74'(1'b0));

        // Extension variants and unknown op code
        do_load("ld_h_neg", 3'b011, 32'h4000, 32'h1234_8765, 32'hFFFF_8765);
        do_load("ld_bu_lane3", 3'b010, 32'h4003, 32'hAB00_0000, 32'h0000_00AB);
        do_load("ld_b_lane1_pos", 3'b001, 32'h4001, 32'h0000_7F00, 32'h0000_007F);
        do_load("ld_h_upper", 3'b011, 32'h4002, 32'h8002_0000, 32'hFFFF_8002);
        do_load("ld_bu_lane0", 3'b010, 32'h4000, 32'h0000_00F0, 32'h0000_00F0);
        do_load("ld_unknown_w", 3'b111, 32'h4001, 32'h9876_5432, 32'h9876_5432);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
